// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory path: responder FSM states and
// default geometry / latency constants.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } dmem_state_t;

    localparam int DMEM_DEPTH_WORDS = 256;
    localparam int DMEM_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// Word-wide data storage: synchronous write port, registered read port.
// Only the read register is reset; the storage itself keeps its contents.
module dmem_array #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wr_data,
    output logic [31:0]                    rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder with IDLE/WAIT/RESPOND handshake FSM.
// Define DMEM_WAIT_STATES_EN to insert WAIT_CYCLES wait states per access.
//
// Handshake: the initiator raises exactly one of mem_read_en/mem_write_en with
// a word-aligned address and holds everything stable while mem_stall is high;
// mem_ready pulses for one cycle when the access completes (load data valid in
// that cycle); addr_error pulses the cycle after a malformed request is seen.
module data_mem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_access_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        addr_error,
    output dmem_state_t fsm_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

    dmem_state_t state, next_state;
    logic [3:0]  wait_cnt, next_cnt;
    logic        req_any, req_valid, req_bad;
    logic        do_rd, do_wr;
    logic        err_q;
    logic        unused_addr_bits;

    assign req_any   = mem_read_en | mem_write_en;
    assign req_valid = (mem_read_en ^ mem_write_en) && (mem_access_addr[1:0] == 2'b00);
    assign req_bad   = req_any && !req_valid;

    // Upper address bits alias onto the array.
    assign unused_addr_bits = ^mem_access_addr[31:AW+2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            // A held malformed request cannot produce a level, only pulses.
            err_q    <= (state == IDLE) && req_bad && !err_q;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        do_rd      = 1'b0;
        do_wr      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef DMEM_WAIT_STATES_EN
                    next_state = WAIT;
                    next_cnt   = '0;
`else
                    next_state = RESPOND;
                    do_rd      = mem_read_en;
                    do_wr      = mem_write_en;
`endif
                end
            end
            WAIT: begin
                if (!req_valid) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (wait_cnt == LAST_WAIT) begin
                    // The array is touched on the edge that enters RESPOND.
                    next_state = RESPOND;
                    next_cnt   = '0;
                    do_rd      = mem_read_en;
                    do_wr      = mem_write_en;
                end else begin
                    next_cnt = wait_cnt + 4'd1;
                end
            end
            RESPOND: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign mem_ready  = (state == RESPOND);
    assign mem_stall  = req_valid && !mem_ready;
    assign addr_error = err_q;
    assign fsm_state  = state;

    // Gating with reset keeps an edge during reset from committing a store.
    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (do_wr && reset),
        .rd_en  (do_rd && reset),
        .idx    (mem_access_addr[AW+1:2]),
        .wr_data(mem_write_data),
        .rd_data(mem_read_data)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder (either wait-state build).
module tb_data_mem_responder;
    import mips_pkg::*;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;
`ifdef DMEM_WAIT_STATES_EN
    localparam int LAT = WAITC + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_access_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic        mem_write_en = 1'b0;
    logic        mem_read_en = 1'b0;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic        mem_stall;
    logic        addr_error;
    dmem_state_t fsm_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        reject;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_access_addr(mem_access_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .mem_stall      (mem_stall),
        .addr_error     (addr_error),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        mem_read_en     = rd;
        mem_write_en    = wr;
        mem_access_addr = a;
        mem_write_data  = d;
    endtask

    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rdata);
        int stalls = 0;
        int errs = 0;
        int lat = -1;
        @(posedge clk); #1;
        drive(rd, wr, a, d);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            if (addr_error) errs++;
            if (mem_ready) begin
                lat = k;
                check({name, "_ready_data"}, mem_read_data, exp_rdata);
                break;
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        check({name, "_latency"}, 32'(lat), 32'(LAT));
        check({name, "_stall_cycles"}, 32'(stalls), 32'(LAT));
        check({name, "_no_error"}, 32'(errs), 32'd0);
        @(negedge clk);
        check({name, "_ready_pulse_end"}, 32'(mem_ready), 32'd0);
        check({name, "_held_data"}, mem_read_data, exp_rdata);
    endtask

    task automatic run_reject(input string name, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rdata);
        int errs = 0;
        int rdys = 0;
        @(posedge clk); #1;
        drive(rd, wr, a, d);
        @(negedge clk);
        check({name, "_no_stall"}, 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (addr_error) errs++;
            if (mem_ready) rdys++;
        end
        check({name, "_error_pulses"}, 32'(errs), 32'd1);
        check({name, "_no_ready"}, 32'(rdys), 32'd0);
        check({name, "_data_unchanged"}, mem_read_data, exp_rdata);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_1234, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_1234};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0000_1234};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h2222_2222, 1'b1, 32'h0000_1234};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h1111_1111};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h1111_1111};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_07FC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 1'b0, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

        // Reset state while reset is held low.
        repeat (2) @(negedge clk);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_error", 32'(addr_error), 32'd0);
        check("reset_rdata", mem_read_data, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].reject)
                run_reject($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                           vecs[i].wdata, vecs[i].exp_rdata);
            else
                run_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                           vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Reset in the middle of a store to 0x20: outputs clear at once, no write.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h9999_9999);
        @(negedge clk);
`ifdef DMEM_WAIT_STATES_EN
        @(negedge clk);
        check("mid_store_in_wait", 32'(fsm_state), 32'(WAIT));
`endif
        reset = 1'b0;
        #1;
        check("async_reset_state", 32'(fsm_state), 32'(IDLE));
        check("async_reset_ready", 32'(mem_ready), 32'd0);
        check("async_reset_error", 32'(addr_error), 32'd0);
        check("async_reset_rdata", mem_read_data, 32'd0);
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b1;
        run_access("post_reset_load", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111);

`ifdef DMEM_WAIT_STATES_EN
        // Enable dropped during WAIT aborts the store.
        begin
            int rdys = 0;
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 32'h0000_0030, 32'h5A5A_5A5A);
            @(posedge clk); #1;
            drive(1'b0, 1'b0, '0, '0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (mem_ready) rdys++;
            end
            check("abort_no_ready", 32'(rdys), 32'd0);
            check("abort_state", 32'(fsm_state), 32'(IDLE));
            run_access("abort_load", 1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'hA5A5_A5A5);
        end
`endif

        // Held load request: each completion is followed by a fresh access.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        for (int k = 0; k < 3 * (LAT + 1); k++) begin
            logic exp_rdy;
            @(negedge clk);
            exp_rdy = ((k % (LAT + 1)) == LAT);
            check($sformatf("b2b_ready_c%0d", k), 32'(mem_ready), 32'(exp_rdy));
            check($sformatf("b2b_stall_c%0d", k), 32'(mem_stall), 32'(!exp_rdy));
            if (exp_rdy) check($sformatf("b2b_data_c%0d", k), mem_read_data, 32'h0000_1234);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("b2b_idle_after", 32'(fsm_state), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
